nes_pad_responder: RTL and testbench

NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

---
 rtl/nes_pkg.sv | 23 ++
 rtl/sync_edge.sv | 29 ++
 rtl/nes_pad_responder.sv | 108 ++++++++++
 tb/tb_nes_pad_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared NES pad definitions: button bit order, frame length and
// the responder state encoding.
package nes_pkg;

    localparam int NES_BITS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        SHIFTING,
        EXHAUSTED
    } padState_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous strobe plus a
// one-flop rising-edge detector on the synchronized level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetN,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;

endmodule

// File: rtl/nes_pad_responder.sv
// NES controller responder: snapshots the buttons while latched and
// shifts them out active-low on each pulse edge, with link timeout.
module nes_pad_responder
    import nes_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       pixelClock,
    input  logic       resetN,
    input  logic       padLatch,
    input  logic       padPulse,
    input  logic [7:0] buttons,
    output logic       padData,
    output logic       frameDone,
    output logic [3:0] bitIndex,
    output logic       linkActive
);

    localparam logic [19:0] TIMEOUT = 20'(TIMEOUT_CYCLES);
    localparam logic [3:0]  LAST    = 4'(NES_BITS);

    logic       latchLevel;
    logic       latchRise;
    logic       unusedPulseLevel;
    logic       pulseRise;

    padState_t  state;
    logic [7:0] snapshot;
    logic [19:0] idleCount;
    logic [3:0] nextIdx;
    logic       timeoutHit;

    sync_edge #(.STAGES(SYNC_STAGES)) latchSync (
        .clk    (pixelClock),
        .resetN (resetN),
        .din    (padLatch),
        .level  (latchLevel),
        .rise   (latchRise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) pulseSync (
        .clk    (pixelClock),
        .resetN (resetN),
        .din    (padPulse),
        .level  (unusedPulseLevel),
        .rise   (pulseRise)
    );

    assign nextIdx    = bitIndex + 4'd1;
    assign timeoutHit = !latchRise && (idleCount == TIMEOUT - 20'd1);

    // Idle counter saturates at TIMEOUT so the loss event fires once.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            idleCount  <= '0;
            linkActive <= 1'b0;
        end else if (latchRise) begin
            idleCount  <= '0;
            linkActive <= 1'b1;
        end else if (idleCount != TIMEOUT) begin
            idleCount <= idleCount + 20'd1;
            if (timeoutHit) begin
                linkActive <= 1'b0;
            end
        end
    end

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            snapshot  <= '0;
            padData   <= 1'b1;
            frameDone <= 1'b0;
            bitIndex  <= '0;
        end else begin
            frameDone <= 1'b0;
            if (latchLevel) begin
                state    <= LOADING;
                snapshot <= buttons;
                bitIndex <= '0;
                padData  <= ~buttons[BTN_A];
            end else if (timeoutHit) begin
                state    <= IDLE;
                bitIndex <= '0;
                padData  <= 1'b1;
            end else begin
                unique case (state)
                    LOADING: state <= SHIFTING;
                    SHIFTING: begin
                        if (pulseRise) begin
                            bitIndex <= nextIdx;
                            if (nextIdx == LAST) begin
                                padData   <= 1'b0;
                                frameDone <= 1'b1;
                                state     <= EXHAUSTED;
                            end else begin
                                padData <= ~snapshot[nextIdx[2:0]];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder with a pulse scoreboard and
// a small reference model of the shift register.
module tb_nes_pad_responder;

    logic       pixelClock = 1'b0;
    logic       resetN;
    logic       padLatch;
    logic       padPulse;
    logic [7:0] buttons;
    logic       padData;
    logic       frameDone;
    logic [3:0] bitIndex;
    logic       linkActive;

    int tests = 0;
    int fails = 0;
    int fdSeen = 0;
    int mFrames = 0;

    typedef struct {
        logic       pd;
        logic [3:0] idx;
    } exp_t;

    exp_t sb[$];

    logic [7:0] mSnap = '0;
    logic [3:0] mIdx = '0;
    logic       mPd = 1'b1;
    logic       mShift = 1'b0;

    nes_pad_responder #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .pixelClock (pixelClock),
        .resetN     (resetN),
        .padLatch   (padLatch),
        .padPulse   (padPulse),
        .buttons    (buttons),
        .padData    (padData),
        .frameDone  (frameDone),
        .bitIndex   (bitIndex),
        .linkActive (linkActive)
    );

    always #5 pixelClock = ~pixelClock;

    always @(negedge pixelClock) begin
        if (resetN === 1'b1 && frameDone === 1'b1) fdSeen++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic latchFrame(input logic [7:0] b);
        logic e;
        e = ~b[0];
        @(negedge pixelClock);
        buttons  = b;
        padLatch = 1'b1;
        repeat (6) @(negedge pixelClock);
        check("latchData", padData, e);
        check("latchIdx", bitIndex, 0);
        check("latchLink", linkActive, 1);
        padLatch = 1'b0;
        mSnap  = b;
        mIdx   = 4'd0;
        mPd    = e;
        mShift = 1'b1;
        repeat (4) @(negedge pixelClock);
    endtask

    task automatic pulse();
        logic [3:0] prevIdx;
        exp_t e;
        prevIdx = mIdx;
        if (mShift && mIdx < 4'd8) begin
            mIdx = mIdx + 4'd1;
            if (mIdx == 4'd8) begin
                mPd = 1'b0;
                mFrames++;
            end else begin
                mPd = ~mSnap[mIdx[2:0]];
            end
        end
        sb.push_back('{pd: mPd, idx: mIdx});
        @(negedge pixelClock);
        padPulse = 1'b1;
        repeat (2) @(posedge pixelClock);
        #1;
        check("pulseEarly", bitIndex, prevIdx);
        @(posedge pixelClock);
        #1;
        e = sb.pop_front();
        check("pulseData", padData, e.pd);
        check("pulseIdx", bitIndex, e.idx);
        padPulse = 1'b0;
        repeat (2) @(negedge pixelClock);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetN   = 1'b0;
        padLatch = 1'b0;
        padPulse = 1'b0;
        buttons  = 8'h00;
        repeat (3) @(negedge pixelClock);
        check("rstData", padData, 1);
        check("rstDone", frameDone, 0);
        check("rstIdx", bitIndex, 0);
        check("rstLink", linkActive, 0);
        resetN = 1'b1;
        repeat (3) @(negedge pixelClock);

        // Full frame: A and Select pressed.
        fdSeen = 0;
        mFrames = 0;
        latchFrame(8'b0000_0101);
        for (int i = 0; i < 8; i++) pulse();
        repeat (3) @(negedge pixelClock);
        check("frameDoneCnt", fdSeen, mFrames);
        check("frameDoneOne", fdSeen, 1);

        // Snapshot hold against buttons changing after the latch.
        latchFrame(8'h00);
        buttons = 8'hFF;
        for (int i = 0; i < 7; i++) pulse();
        check("holdIdx7", bitIndex, 7);
        check("holdData7", padData, 1);
        pulse();

        // Over-read.
        fdSeen = 0;
        mFrames = 0;
        latchFrame(8'hA5);
        for (int i = 0; i < 12; i++) pulse();
        repeat (3) @(negedge pixelClock);
        check("overIdx", bitIndex, 8);
        check("overData", padData, 0);
        check("overDone", fdSeen, 1);

        // Latch and pulse arrive together: latch wins.
        latchFrame(8'hFF);
        pulse();
        pulse();
        @(negedge pixelClock);
        buttons  = 8'h3C;
        padLatch = 1'b1;
        padPulse = 1'b1;
        repeat (3) @(posedge pixelClock);
        #1;
        check("collIdx", bitIndex, 0);
        check("collData", padData, 1);
        repeat (3) @(negedge pixelClock);
        padLatch = 1'b0;
        padPulse = 1'b0;
        mSnap  = 8'h3C;
        mIdx   = 4'd0;
        mPd    = 1'b1;
        mShift = 1'b1;
        repeat (4) @(negedge pixelClock);
        pulse();
        pulse();

        // Reset in the middle of a frame.
        latchFrame(8'h0F);
        pulse();
        pulse();
        pulse();
        @(negedge pixelClock);
        resetN = 1'b0;
        mShift = 1'b0;
        mIdx   = 4'd0;
        mPd    = 1'b1;
        @(negedge pixelClock);
        check("midRstData", padData, 1);
        check("midRstIdx", bitIndex, 0);
        check("midRstLink", linkActive, 0);
        check("midRstDone", frameDone, 0);
        resetN = 1'b1;
        repeat (3) @(negedge pixelClock);
        pulse();
        pulse();

        // Link timeout with TIMEOUT_CYCLES = 100.
        @(negedge pixelClock);
        buttons  = 8'h01;
        padLatch = 1'b1;
        n = 0;
        while (linkActive !== 1'b1 && n < 10) begin
            @(posedge pixelClock);
            #1;
            n++;
        end
        check("toLinkUp", linkActive, 1);
        for (int i = 1; i <= 100; i++) begin
            @(posedge pixelClock);
            #1;
            if (i == 10) padLatch = 1'b0;
            if (i == 99) begin
                check("toBeforeLink", linkActive, 1);
                check("toBeforeData", padData, 0);
            end
            if (i == 100) begin
                check("toLinkLost", linkActive, 0);
                check("toIdleData", padData, 1);
            end
        end
        @(negedge pixelClock);
        padLatch = 1'b1;
        n = 0;
        while (linkActive !== 1'b1 && n < 10) begin
            @(posedge pixelClock);
            #1;
            n++;
        end
        check("toRelink", linkActive, 1);
        padLatch = 1'b0;
        repeat (4) @(negedge pixelClock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
